qmax_update_engine: RTL and testbench

Sequencer-plus-datapath stage that consumes transitions (s, a, r, s') and performs the Q-learning update against the Q-value table and the per-state Qmax table (both 1-cycle-read BRAMs). It reads Qmax(s') and Q(s,a), computes Q'(s,a) in saturating fixed point, writes Q'(s,a) back, and raises Qmax(s) when Q' exceeds it. After reset it also zero-initialises both tables, since neither table has a reset of its own.

---
 rtl/qlearn_pkg.sv | 40 ++++
 rtl/qupdate_alu.sv | 45 ++++
 rtl/qmax_update_engine.sv | 194 +++++++++++++++++++
 tb/tb_qmax_update_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qlearn_pkg.sv
// Shared definitions for the Q-learning update engine.
//   - default table/value widths and shift amounts
//   - sequencer state encoding
//   - sat(): clamp a wide signed value into a dw-bit signed range
package qlearn_pkg;

    localparam int ADDR_WIDTH_DEF  = 6;
    localparam int ACT_WIDTH_DEF   = 2;
    localparam int DATA_WIDTH_DEF  = 32;
    localparam int ALPHA_SHIFT_DEF = 1;
    localparam int GAMMA_SHIFT_DEF = 3;

    // Working width of sat(); covers DATA_WIDTH up to 64 with sign headroom.
    localparam int SAT_W = 68;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_NXT,
        ST_RD_CUR,
        ST_CALC,
        ST_WR
    } state_e;

    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                    input int unsigned dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
        lo = ~hi;   // -hi - 1
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/qupdate_alu.sv
// Combinational Q-learning update datapath.
//   reward_i : r, signed
//   qn_i     : Qmax(s'), signed
//   q_i      : Q(s,a), signed
//   q_new_o  : Q'(s,a) = sat(q + ((sat(r + qn - qn>>>G) - q) >>> A))
// Everything is evaluated two bits wider than DATA_WIDTH so that no
// intermediate sum can wrap before it is clamped.
module qupdate_alu
    import qlearn_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ALPHA_SHIFT = ALPHA_SHIFT_DEF,
    parameter int GAMMA_SHIFT = GAMMA_SHIFT_DEF
) (
    input  logic [DATA_WIDTH-1:0] reward_i,
    input  logic [DATA_WIDTH-1:0] qn_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic [DATA_WIDTH-1:0] q_new_o
);

    localparam int E = DATA_WIDTH + 2;

    logic signed [E-1:0] r_e;
    logic signed [E-1:0] qn_e;
    logic signed [E-1:0] q_e;
    logic signed [E-1:0] g;
    logic signed [E-1:0] rg;
    logic signed [E-1:0] t;
    logic signed [E-1:0] d;
    logic signed [E-1:0] sum;

    assign r_e  = {{2{reward_i[DATA_WIDTH-1]}}, reward_i};
    assign qn_e = {{2{qn_i[DATA_WIDTH-1]}}, qn_i};
    assign q_e  = {{2{q_i[DATA_WIDTH-1]}}, q_i};

    // gamma * qn with gamma = 1 - 2^-GAMMA_SHIFT
    assign g   = qn_e - (qn_e >>> GAMMA_SHIFT);
    assign rg  = r_e + g;
    assign t   = E'(sat({{(SAT_W-E){rg[E-1]}}, rg}, DATA_WIDTH));
    assign d   = t - q_e;
    assign sum = q_e + (d >>> ALPHA_SHIFT);

    assign q_new_o = DATA_WIDTH'(sat({{(SAT_W-E){sum[E-1]}}, sum}, DATA_WIDTH));

endmodule

// File: rtl/qmax_update_engine.sv
// Q-learning update sequencer. Accepts (s, a, r, s'), reads Qmax(s') and
// Q(s,a), then Qmax(s), computes Q'(s,a) and writes it back, raising
// Qmax(s) when Q' exceeds it. After reset it zero-fills both tables.
//
// Ports
//   i_clk, i_rst_n            clock, async active-low reset
//   i_valid / o_ready         transition handshake
//   i_state, i_action,
//   i_next_state, i_reward    transition (s, a, s', r)
//   o_done, o_q_new           one-cycle completion pulse with Q'(s,a)
//   o_init_busy               table clear in progress
//   o_qmax_*, i_qmax_rdata    Qmax table port (1-cycle read latency)
//   o_q_*, i_q_rdata          Q table port, address {s, a}
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_INIT   | sweep k over all Q addresses writing 0; Qmax[k>>ACT] on a==0
// ST_IDLE   | o_ready, latch transition on i_valid
// ST_RD_NXT | read Qmax[s'] and Q[s,a]
// ST_RD_CUR | capture qn, q; read Qmax[s]
// ST_CALC   | capture qc; register Q'
// ST_WR     | write Q[s,a]; write Qmax[s] if Q' > qc; o_done
module qmax_update_engine
    import qlearn_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int ACT_WIDTH   = ACT_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ALPHA_SHIFT = ALPHA_SHIFT_DEF,
    parameter int GAMMA_SHIFT = GAMMA_SHIFT_DEF
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [ADDR_WIDTH-1:0]           i_state,
    input  logic [ADDR_WIDTH-1:0]           i_next_state,
    input  logic [ACT_WIDTH-1:0]            i_action,
    input  logic [DATA_WIDTH-1:0]           i_reward,
    output logic                            o_done,
    output logic [DATA_WIDTH-1:0]           o_q_new,
    output logic                            o_init_busy,
    output logic [ADDR_WIDTH-1:0]           o_qmax_addr_r,
    output logic [ADDR_WIDTH-1:0]           o_qmax_addr_w,
    output logic                            o_qmax_read_en,
    output logic                            o_qmax_write_en,
    output logic [DATA_WIDTH-1:0]           o_qmax_wdata,
    input  logic [DATA_WIDTH-1:0]           i_qmax_rdata,
    output logic [ADDR_WIDTH+ACT_WIDTH-1:0] o_q_addr_r,
    output logic [ADDR_WIDTH+ACT_WIDTH-1:0] o_q_addr_w,
    output logic                            o_q_read_en,
    output logic                            o_q_write_en,
    output logic [DATA_WIDTH-1:0]           o_q_wdata,
    input  logic [DATA_WIDTH-1:0]           i_q_rdata
);

    localparam int QA_W = ADDR_WIDTH + ACT_WIDTH;

    state_e                 state_q, state_d;
    logic [QA_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  s_q, s_d, sn_q, sn_d;
    logic [ACT_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]  r_q, r_d, qn_q, qn_d, q_q, q_d, qc_q, qc_d, qnew_q, qnew_d;
    logic [DATA_WIDTH-1:0]  alu_q_new;

    logic ready_c, done_c, busy_c, q_re_c, q_we_c, qm_re_c, qm_we_c;

    qupdate_alu #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .GAMMA_SHIFT (GAMMA_SHIFT)
    ) u_alu (
        .reward_i (r_q),
        .qn_i     (qn_q),
        .q_i      (q_q),
        .q_new_o  (alu_q_new)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            s_q     <= '0;
            sn_q    <= '0;
            a_q     <= '0;
            r_q     <= '0;
            qn_q    <= '0;
            q_q     <= '0;
            qc_q    <= '0;
            qnew_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            sn_q    <= sn_d;
            a_q     <= a_d;
            r_q     <= r_d;
            qn_q    <= qn_d;
            q_q     <= q_d;
            qc_q    <= qc_d;
            qnew_q  <= qnew_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        s_d           = s_q;
        sn_d          = sn_q;
        a_d           = a_q;
        r_d           = r_q;
        qn_d          = qn_q;
        q_d           = q_q;
        qc_d          = qc_q;
        qnew_d        = qnew_q;
        ready_c       = 1'b0;
        done_c        = 1'b0;
        busy_c        = 1'b0;
        q_re_c        = 1'b0;
        q_we_c        = 1'b0;
        qm_re_c       = 1'b0;
        qm_we_c       = 1'b0;
        o_qmax_addr_r = s_q;
        o_qmax_addr_w = s_q;
        o_q_addr_r    = {s_q, a_q};
        o_q_addr_w    = {s_q, a_q};
        o_q_wdata     = '0;
        o_qmax_wdata  = '0;

        case (state_q)
            ST_INIT: begin
                busy_c        = 1'b1;
                q_we_c        = 1'b1;
                qm_we_c       = (cnt_q[ACT_WIDTH-1:0] == '0);
                o_q_addr_w    = cnt_q;
                o_qmax_addr_w = cnt_q[QA_W-1:ACT_WIDTH];
                cnt_d         = cnt_q + QA_W'(1);
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ready_c = 1'b1;
                if (i_valid) begin
                    s_d     = i_state;
                    a_d     = i_action;
                    sn_d    = i_next_state;
                    r_d     = i_reward;
                    state_d = ST_RD_NXT;
                end
            end
            ST_RD_NXT: begin
                qm_re_c       = 1'b1;
                q_re_c        = 1'b1;
                o_qmax_addr_r = sn_q;
                state_d       = ST_RD_CUR;
            end
            ST_RD_CUR: begin
                qn_d    = i_qmax_rdata;
                q_d     = i_q_rdata;
                qm_re_c = 1'b1;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                qc_d    = i_qmax_rdata;
                qnew_d  = alu_q_new;
                state_d = ST_WR;
            end
            ST_WR: begin
                done_c       = 1'b1;
                q_we_c       = 1'b1;
                qm_we_c      = ($signed(qnew_q) > $signed(qc_q));
                o_q_wdata    = qnew_q;
                o_qmax_wdata = qnew_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Strobes are held low for the whole reset interval, not just after the
    // first edge, so an aborted update can never leak a write.
    assign o_ready         = ready_c & i_rst_n;
    assign o_done          = done_c  & i_rst_n;
    assign o_init_busy     = busy_c  & i_rst_n;
    assign o_q_read_en     = q_re_c  & i_rst_n;
    assign o_q_write_en    = q_we_c  & i_rst_n;
    assign o_qmax_read_en  = qm_re_c & i_rst_n;
    assign o_qmax_write_en = qm_we_c & i_rst_n;
    assign o_q_new         = qnew_q;

endmodule

// File: tb/tb_qmax_update_engine.sv
module tb_qmax_update_engine;

    localparam int AW    = 6;
    localparam int ACTW  = 2;
    localparam int DW    = 32;
    localparam int ALPHA = 1;
    localparam int GAMMA = 3;
    localparam int QAW   = AW + ACTW;
    localparam int NQ    = 1 << QAW;
    localparam int NS    = 1 << AW;
    localparam longint SMAX = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint SMIN = -SMAX - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid = 1'b0;
    logic            ready, done, busy;
    logic [AW-1:0]   st = '0, nst = '0;
    logic [ACTW-1:0] act = '0;
    logic [DW-1:0]   rew = '0;
    logic [DW-1:0]   q_new;
    logic [AW-1:0]   qm_addr_r, qm_addr_w;
    logic            qm_re, qm_we;
    logic [DW-1:0]   qm_wdata, qm_rdata;
    logic [QAW-1:0]  q_addr_r, q_addr_w;
    logic            q_re, q_we;
    logic [DW-1:0]   q_wdata, q_rdata;

    always #5 clk = ~clk;

    qmax_update_engine #(
        .ADDR_WIDTH (AW), .ACT_WIDTH (ACTW), .DATA_WIDTH (DW),
        .ALPHA_SHIFT (ALPHA), .GAMMA_SHIFT (GAMMA)
    ) dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_valid (valid), .o_ready (ready),
        .i_state (st), .i_next_state (nst), .i_action (act), .i_reward (rew),
        .o_done (done), .o_q_new (q_new), .o_init_busy (busy),
        .o_qmax_addr_r (qm_addr_r), .o_qmax_addr_w (qm_addr_w),
        .o_qmax_read_en (qm_re), .o_qmax_write_en (qm_we),
        .o_qmax_wdata (qm_wdata), .i_qmax_rdata (qm_rdata),
        .o_q_addr_r (q_addr_r), .o_q_addr_w (q_addr_w),
        .o_q_read_en (q_re), .o_q_write_en (q_we),
        .o_q_wdata (q_wdata), .i_q_rdata (q_rdata)
    );

    // Table BRAMs with 1-cycle read latency plus a preload/fill back door.
    logic [DW-1:0]  q_mem [NQ];
    logic [DW-1:0]  qm_mem [NS];
    logic           fill_en = 1'b0, pl_q_en = 1'b0, pl_qm_en = 1'b0;
    logic [QAW-1:0] pl_q_addr = '0;
    logic [AW-1:0]  pl_qm_addr = '0;
    logic [DW-1:0]  pl_data = '0;

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < NQ; i++) q_mem[i] <= 32'hDEADBEEF;
            for (int i = 0; i < NS; i++) qm_mem[i] <= 32'hDEADBEEF;
        end
        if (pl_q_en)  q_mem[pl_q_addr]   <= pl_data;
        if (pl_qm_en) qm_mem[pl_qm_addr] <= pl_data;
        if (q_we)     q_mem[q_addr_w]    <= q_wdata;
        if (qm_we)    qm_mem[qm_addr_w]  <= qm_wdata;
        if (q_re)     q_rdata  <= q_mem[q_addr_r];
        if (qm_re)    qm_rdata <= qm_mem[qm_addr_r];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int ref_q  [NQ];
    int ref_qm [NS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // floor(x / 2^sh)
    function automatic longint fl_shr(input longint x, input int sh);
        longint p;
        p = longint'(1) <<< sh;
        if (x >= 0) return x / p;
        return -((-x + p - 1) / p);
    endfunction

    function automatic longint clamp(input longint x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    function automatic int model_q(input int r, input int qn, input int q);
        longint g, t, d;
        g = longint'(qn) - fl_shr(longint'(qn), GAMMA);
        t = clamp(longint'(r) + g);
        d = t - longint'(q);
        return int'(clamp(longint'(q) + fl_shr(d, ALPHA)));
    endfunction

    task automatic preload_q(input int idx, input int val);
        pl_q_addr = QAW'(idx); pl_data = val; pl_q_en = 1'b1;
        @(posedge clk); @(negedge clk);
        pl_q_en = 1'b0;
        ref_q[idx] = val;
    endtask

    task automatic preload_qm(input int idx, input int val);
        pl_qm_addr = AW'(idx); pl_data = val; pl_qm_en = 1'b1;
        @(posedge clk); @(negedge clk);
        pl_qm_en = 1'b0;
        ref_qm[idx] = val;
    endtask

    task automatic run_txn(input int s, input int a, input int sn, input int r,
                           output logic [31:0] qnew_obs);
        int idx, exp, qc, w, lat;
        logic exp_wr, got_qwe, got_qmwe, got_qre;
        logic [QAW-1:0] got_qa;
        logic [AW-1:0] got_qma;
        idx    = s * (1 << ACTW) + a;
        qc     = ref_qm[s];
        exp    = model_q(r, ref_qm[sn], ref_q[idx]);
        exp_wr = (exp > qc);
        w = 0;
        while (!ready && w < 20) begin @(negedge clk); w++; end
        check("ready_before_txn", 32'(ready), 32'd1);
        st = AW'(s); act = ACTW'(a); nst = AW'(sn); rew = r; valid = 1'b1;
        @(posedge clk); @(negedge clk);
        valid = 1'b0;
        st = AW'($urandom); act = ACTW'($urandom); nst = AW'($urandom); rew = $urandom;
        lat = 0; qnew_obs = '0; got_qwe = 0; got_qmwe = 0; got_qre = 1; got_qa = '0; got_qma = '0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if (done) begin
                lat = c; qnew_obs = q_new; got_qwe = q_we; got_qmwe = qm_we;
                got_qa = q_addr_w; got_qma = qm_addr_w; got_qre = q_re;
            end else begin
                @(negedge clk);
            end
        end
        check("done_latency", 32'(lat), 32'd4);
        check("q_new", qnew_obs, exp);
        check("q_write_en", 32'(got_qwe), 32'd1);
        check("q_addr_w", 32'(got_qa), 32'(idx));
        check("qmax_write_en", 32'(got_qmwe), 32'(exp_wr));
        check("qmax_addr_w", 32'(got_qma), 32'(s));
        check("q_read_during_write", 32'(got_qre), 32'd0);
        @(negedge clk);
        check("ready_after_txn", 32'(ready), 32'd1);
        check("q_mem_written", q_mem[idx], exp);
        check("qmax_mem", qm_mem[s], exp_wr ? exp : qc);
        ref_q[idx] = exp;
        if (exp_wr) ref_qm[s] = exp;
    endtask

    function automatic int rand_val();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 2000)) - 1000;
    endfunction

    initial begin
        logic [31:0] obs;
        int busy_n, nqw, nqmw, rdy_in_init, nz_q, nz_qm, done_seen;

        fill_en = 1'b1;
        @(posedge clk); @(negedge clk);
        fill_en = 1'b0;

        check("rst_ready", 32'(ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_q_we", 32'(q_we), 0);
        check("rst_qmax_we", 32'(qm_we), 0);
        check("rst_reads", 32'({q_re, qm_re}), 0);
        check("rst_q_new", q_new, 0);

        // Initial table sweep
        rst_n = 1'b1;
        #1;
        busy_n = 0; nqw = 0; nqmw = 0; rdy_in_init = 0;
        while (busy && busy_n < 400) begin
            busy_n++;
            if (q_we && q_wdata == '0) nqw++;
            if (qm_we && qm_wdata == '0) nqmw++;
            if (ready) rdy_in_init++;
            @(negedge clk);
        end
        check("init_cycles", 32'(busy_n), 32'(NQ));
        check("init_q_writes", 32'(nqw), 32'(NQ));
        check("init_qmax_writes", 32'(nqmw), 32'(NS));
        check("init_ready_low", 32'(rdy_in_init), 0);
        check("ready_after_init", 32'(ready), 1);
        nz_q = 0; nz_qm = 0;
        for (int i = 0; i < NQ; i++) begin if (q_mem[i] !== '0) nz_q++; ref_q[i] = 0; end
        for (int i = 0; i < NS; i++) begin if (qm_mem[i] !== '0) nz_qm++; ref_qm[i] = 0; end
        check("init_q_zero", 32'(nz_q), 0);
        check("init_qmax_zero", 32'(nz_qm), 0);

        // Directed updates
        preload_qm(5, 64); preload_q(13, 0); preload_qm(3, 0);
        run_txn(3, 1, 5, 8, obs);
        check("dir_basic", obs, 32);
        check("dir_basic_qmax3", qm_mem[3], 32);

        preload_qm(3, 100); preload_q(13, 0); preload_qm(5, 64);
        run_txn(3, 1, 5, 8, obs);
        check("dir_no_raise", obs, 32);
        check("dir_no_raise_qmax3", qm_mem[3], 100);

        preload_qm(7, 32'h7FFFFFFF); preload_q(8, 32'h7FFFFFFF);
        run_txn(2, 0, 7, 32'h7FFFFFF0, obs);
        check("dir_sat_pos", obs, 32'h7FFFFFFF);

        preload_qm(9, 32'h80000000); preload_q(19, 32'h80000000);
        run_txn(4, 3, 9, 32'h80000000, obs);
        check("dir_sat_neg", obs, 32'h80000000);

        preload_qm(11, 0); preload_q(42, 0); preload_qm(10, 0);
        run_txn(10, 2, 11, -16, obs);
        check("dir_negative", obs, 32'hFFFFFFF8);
        check("dir_negative_qmax", qm_mem[10], 0);

        // Same state as next state
        preload_qm(20, 40); preload_q(81, 10);
        run_txn(20, 1, 20, 4, obs);

        // Randomized updates against the reference model
        for (int n = 0; n < 40; n++) begin
            int s, a, sn;
            s  = int'($urandom_range(0, NS - 1));
            a  = int'($urandom_range(0, (1 << ACTW) - 1));
            sn = int'($urandom_range(0, NS - 1));
            if ($urandom_range(0, 1) == 1) preload_q(s * (1 << ACTW) + a, rand_val());
            if ($urandom_range(0, 1) == 1) preload_qm(sn, rand_val());
            if ($urandom_range(0, 1) == 1) preload_qm(s, rand_val());
            run_txn(s, a, sn, rand_val(), obs);
        end

        // Reset asserted mid-update (in the compute cycle)
        while (!ready) @(negedge clk);
        st = 1; act = 1; nst = 2; rew = 1000; valid = 1'b1;
        @(posedge clk); @(negedge clk);          // cycle 1
        valid = 1'b0;
        @(negedge clk);                          // cycle 2
        @(negedge clk);                          // cycle 3
        rst_n = 1'b0;
        #1;
        check("abort_done", 32'(done), 0);
        check("abort_q_we", 32'(q_we), 0);
        check("abort_qmax_we", 32'(qm_we), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(ready), 0);
        valid = 1'b1;
        @(negedge clk);
        check("abort_writes_cycle4", 32'({q_we, qm_we, done}), 0);
        rst_n = 1'b1;
        #1;
        busy_n = 0; done_seen = 0; rdy_in_init = 0;
        while (busy && busy_n < 400) begin
            busy_n++;
            if (done) done_seen++;
            if (ready) rdy_in_init++;
            @(negedge clk);
        end
        valid = 1'b0;
        check("reinit_cycles", 32'(busy_n), 32'(NQ));
        check("reinit_no_done", 32'(done_seen), 0);
        check("reinit_ready_low", 32'(rdy_in_init), 0);
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("valid_in_init_ignored", 32'(done_seen), 0);
        for (int i = 0; i < NQ; i++) ref_q[i] = 0;
        for (int i = 0; i < NS; i++) ref_qm[i] = 0;
        preload_qm(2, 500);
        run_txn(1, 1, 2, 24, obs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
